ifid_skid_reg: RTL and testbench

Parametrised successor to the basic IF/ID latch. It is a two-entry (main + skid) pipeline stage carrying PC and instruction from fetch to decode, using a valid/ready handshake. It adds flush (bubble insertion), full-throughput backpressure without combinational ready paths, and optional stall/flush counters. It sits between the fetch unit and the decode stage.

---
 rtl/ifid_skid_reg.sv | 97 +++++++++
 tb/tb_ifid_skid_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_reg.sv
// IF/ID two-entry skid stage: main + skid buffer, flush, registered ready.
// Define IFID_PERF_CNT_EN to build the saturating stall/flush counters.
module ifid_skid_reg #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               flush,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic               skid_valid;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic               in_fire;
    logic               out_fire;
    logic               refill;

    assign in_ready = ~skid_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign refill   = ~out_valid | out_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= NOP_INSTR;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (refill) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_pc     <= skid_pc;
                out_instr  <= skid_instr;
                skid_valid <= in_fire;
                if (in_fire) begin
                    skid_pc    <= in_pc;
                    skid_instr <= in_instr;
                end
            end else if (in_fire) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_instr <= in_instr;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            // Main is stalled: park the new beat so ready never depends on out_ready.
            skid_valid <= 1'b1;
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
        end
    end

`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (out_valid && !out_ready && !flush && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (flush && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: directed table, hand sequences, random vs queue model.
module tb_ifid_skid_reg;

    localparam int PC_W = 16;
    localparam int INSTR_W = 16;
    localparam int CNT_W = 4;
    localparam logic [15:0] NOP = 16'hBEEF;
`ifdef IFID_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_pc, in_instr, out_pc, out_instr;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    ifid_skid_reg #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference: FIFO of held beats (capacity 2) plus the displayed value
    logic [31:0] q[$];
    logic [15:0] m_pc = 16'h0;
    logic [15:0] m_ins = NOP;
    int m_stall = 0;
    int m_flush = 0;

    typedef struct {
        bit r, f, iv, ordy;
        logic [15:0] pc, ins;
        bit ev, er;
        logic [15:0] epc, eins;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit iv,
                        input logic [15:0] pc, input logic [15:0] ins,
                        input bit ordy);
        bit fire_in;
        rst = r; flush = f; in_valid = iv;
        in_pc = pc; in_instr = ins; out_ready = ordy;
        if (r) begin
            q.delete(); m_pc = 16'h0; m_ins = NOP;
            m_stall = 0; m_flush = 0;
        end else if (f) begin
            if (m_flush < CMAX) m_flush++;
            q.delete(); m_pc = 16'h0; m_ins = NOP;
        end else begin
            if (q.size() > 0 && !ordy && m_stall < CMAX) m_stall++;
            fire_in = iv && (q.size() < 2);
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (fire_in) q.push_back({pc, ins});
            if (q.size() > 0) begin
                m_pc = q[0][31:16];
                m_ins = q[0][15:0];
            end
        end
        @(posedge clk);
        #1;
        chk("m_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("m_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("m_pc", 32'(out_pc), 32'(m_pc));
        chk("m_instr", 32'(out_instr), 32'(m_ins));
        chk("m_stall", 32'(stall_cnt), PERF ? 32'(m_stall) : 32'h0);
        chk("m_flush", 32'(flush_cnt), PERF ? 32'(m_flush) : 32'h0);
    endtask

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit f, bit iv, logic [15:0] pc,
                                logic [15:0] ins, bit ordy, bit ev, bit er,
                                logic [15:0] epc, logic [15:0] eins);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy;
        v.ev = ev; v.er = er; v.epc = epc; v.eins = eins;
        return v;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_instr = '0; out_ready = 1'b0;

        // reset with a beat presented
        tbl.push_back(mk(1,0,1,16'h0040,16'h1111,1, 0,1,16'h0000,NOP));
        tbl.push_back(mk(1,0,1,16'h0040,16'h1111,1, 0,1,16'h0000,NOP));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,1, 0,1,16'h0000,NOP));
        // streaming
        tbl.push_back(mk(0,0,1,16'h0002,16'hA001,1, 1,1,16'h0002,16'hA001));
        tbl.push_back(mk(0,0,1,16'h0004,16'hA002,1, 1,1,16'h0004,16'hA002));
        tbl.push_back(mk(0,0,1,16'h0006,16'hA003,1, 1,1,16'h0006,16'hA003));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,1, 0,1,16'h0006,16'hA003));
        // backpressure
        tbl.push_back(mk(0,0,1,16'h0010,16'hB010,0, 1,1,16'h0010,16'hB010));
        tbl.push_back(mk(0,0,1,16'h0012,16'hB012,0, 1,0,16'h0010,16'hB010));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0, 1,0,16'h0010,16'hB010));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,1, 1,1,16'h0012,16'hB012));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,1, 0,1,16'h0012,16'hB012));
        // flush with full skid and a beat offered
        tbl.push_back(mk(0,0,1,16'h0020,16'hC020,0, 1,1,16'h0020,16'hC020));
        tbl.push_back(mk(0,0,1,16'h0022,16'hC022,0, 1,0,16'h0020,16'hC020));
        tbl.push_back(mk(0,1,1,16'h0024,16'hC024,0, 0,1,16'h0000,NOP));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,1, 0,1,16'h0000,NOP));
        // drain skid while a beat is offered, then refill from input
        tbl.push_back(mk(0,0,1,16'h0030,16'hD030,0, 1,1,16'h0030,16'hD030));
        tbl.push_back(mk(0,0,1,16'h0032,16'hD032,0, 1,0,16'h0030,16'hD030));
        tbl.push_back(mk(0,0,1,16'h0034,16'hD034,1, 1,1,16'h0032,16'hD032));
        tbl.push_back(mk(0,0,1,16'h0036,16'hD036,1, 1,1,16'h0036,16'hD036));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,1, 0,1,16'h0036,16'hD036));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].pc, tbl[i].ins,
                 tbl[i].ordy);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].er));
            chk($sformatf("tbl%0d_pc", i), 32'(out_pc), 32'(tbl[i].epc));
            chk($sformatf("tbl%0d_instr", i), 32'(out_instr), 32'(tbl[i].eins));
        end

        // counters: 5 stalled cycles then one flush
        step(1, 0, 0, 16'h0, 16'h0, 0);
        step(0, 0, 1, 16'h0050, 16'hE050, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0, 16'h0, 0);
        step(0, 1, 0, 16'h0, 16'h0, 0);
        chk("cnt_stall", 32'(stall_cnt), PERF ? 32'd5 : 32'd0);
        chk("cnt_flush", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);

        // saturation of the narrow counters
        step(0, 0, 1, 16'h0060, 16'hE060, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 16'h0, 16'h0, 0);
        chk("sat_stall", 32'(stall_cnt), PERF ? 32'(CMAX) : 32'd0);
        chk("sat_flush", 32'(flush_cnt), PERF ? 32'(CMAX) : 32'd0);

        // random traffic against the FIFO model
        step(1, 0, 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 9) < 7),
                 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 9) < 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
